// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcode constants, ALU operation classes,
// ALU operand-B selects, PC source selects and the multicycle FSM state
// enumeration. Also used by the single-cycle decoder.
package mips_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // ALU operation classes; the consumer casts to its own alu_op width
    localparam int unsigned AluOpAdd   = 0;
    localparam int unsigned AluOpSub   = 1;
    localparam int unsigned AluOpRtype = 2;

    // ALU operand-B selects
    localparam logic [1:0] AluSrcBReg      = 2'd0;
    localparam logic [1:0] AluSrcBFour     = 2'd1;
    localparam logic [1:0] AluSrcBImm      = 2'd2;
    localparam logic [1:0] AluSrcBImmShift = 2'd3;

    // PC source selects
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecute,
        StRWb,
        StAddiExec,
        StAddiWb,
        StBranch,
        StJump,
        StFault
    } state_e;

    // States that wait on the memory handshake and are covered by the timeout
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter with timeout detection.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset, clears the count
//   clear    - synchronous clear (state entry)
//   count_en - count one wait cycle
//   expired  - count has reached MEM_TIMEOUT (never asserted when MEM_TIMEOUT is 0)
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntWRaw = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned CntW    = (CntWRaw < 1) ? 1 : CntWRaw;

    localparam logic [CntW-1:0] CntOne   = 1;
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT);
    localparam bit              TimeoutEn = (MEM_TIMEOUT != 0);

    logic [CntW-1:0] cnt_q;

    // Saturates at all-ones so a long wait with the timeout disabled never wraps
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    assign expired = TimeoutEn && (cnt_q == CntLimit);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit (LW, SW, R-type, ADDI, BEQ, J).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   opcode          - opcode from the external instruction register (valid from DECODE)
//   mem_ready       - memory handshake completion
//   pc_write .. alu_src_a, alu_src_b, alu_op, pc_source - datapath controls
//   instr_done      - one-cycle pulse when an instruction retires
//   fault           - sticky error (illegal opcode or memory timeout), cleared only by rst
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALU_OP_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_2_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                fault
);

    state_e state_q, state_d;
    logic   in_wait;
    logic   expired;
    logic   timeout;

    assign in_wait = is_wait_state(state_q);
    // Timeout only fires when memory is still not ready; a ready on the limit cycle wins
    assign timeout = in_wait && expired && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .count_en(in_wait && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StFault;
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRtype:    state_d = StExecute;
                    OpAddi:     state_d = StAddiExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFault;
                endcase
            end
            StMemAddr:  state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFault;
            end
            StMemWrite: begin
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StFault;
            end
            StExecute:  state_d = StRWb;
            StAddiExec: state_d = StAddiWb;
            StMemWb, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
            StFault:    state_d = StFault;
            default:    state_d = StFault;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    // While rst is high the outputs look like a FETCH that never completes
    state_e out_st;
    logic   rdy;
    assign out_st = rst ? StFetch : state_q;
    assign rdy    = mem_ready && !rst;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_2_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = AluSrcBReg;
        alu_op        = ALU_OP_W'(AluOpAdd);
        pc_source     = PcSrcAlu;
        instr_done    = 1'b0;
        fault         = 1'b0;
        unique case (out_st)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = AluSrcBFour;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            StDecode:  alu_src_b = AluSrcBImmShift;
            StMemAddr, StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = AluSrcBImm;
            end
            StMemRead: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_2_reg  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = rdy;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_W'(AluOpRtype);
            end
            StRWb: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(AluOpSub);
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
                instr_done    = 1'b1;
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = PcSrcJump;
                instr_done = 1'b1;
            end
            StFault:   fault = 1'b1;
            default:   fault = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, fault;

    multicycle_control_unit #(
        .MEM_TIMEOUT(4),
        .ALU_OP_W   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_2_reg    (mem_2_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .instr_done   (instr_done),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed output word:
    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_2_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0],
    //  instr_done, fault}
    function automatic logic [17:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rdst,
        input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic [1:0] psrc, input logic done, input logic flt);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, flt};
    endfunction

    logic [17:0] e_rst, e_fetch_w, e_fetch_g, e_decode, e_maddr, e_mread, e_mwb;
    logic [17:0] e_mwrite_w, e_mwrite_g, e_exec, e_rwb, e_addi_wb, e_branch, e_jump;
    logic [17:0] e_fault;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [17:0] exp, input string name);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive on the falling edge, compare 1 ns later
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [17:0] exp, input string name);
        logic [17:0] act;
        @(negedge clk);
        rst = r; opcode = op; mem_ready = rdy;
        #1;
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_2_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, fault};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;

        //           pcw pcwc iord mr mw irw m2r rdst rw asa asb   aop   psrc  done flt
        e_rst      = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0);
        e_fetch_w  = e_rst;
        e_fetch_g  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0);
        e_decode   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0);
        e_maddr    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0);
        e_mread    = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
        e_mwb      = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 1, 0);
        e_mwrite_w = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
        e_mwrite_g = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0);
        e_exec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0, 0);
        e_rwb      = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 1, 0);
        e_addi_wb  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 1, 0);
        e_branch   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 1, 0);
        e_jump     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 1, 0);
        e_fault    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 1);

        // Reset: no ir_write/pc_write even with mem_ready high
        add(1, 6'h00, 1, e_rst,      "reset rdy1");
        add(1, 6'h00, 0, e_rst,      "reset rdy0");
        // R-type, zero wait: retire at cycle 4
        add(0, 6'h00, 1, e_fetch_g,  "rtype c1 FETCH");
        add(0, 6'h00, 1, e_decode,   "rtype c2 DECODE");
        add(0, 6'h00, 1, e_exec,     "rtype c3 EXECUTE");
        add(0, 6'h00, 1, e_rwb,      "rtype c4 R_WB");
        // LW with 3 wait cycles in MEM_READ: retire at cycle 8
        add(0, 6'h23, 1, e_fetch_g,  "lw c1 FETCH");
        add(0, 6'h23, 1, e_decode,   "lw c2 DECODE");
        add(0, 6'h23, 1, e_maddr,    "lw c3 MEM_ADDR");
        add(0, 6'h23, 0, e_mread,    "lw c4 MEM_READ wait");
        add(0, 6'h23, 0, e_mread,    "lw c5 MEM_READ wait");
        add(0, 6'h23, 0, e_mread,    "lw c6 MEM_READ wait");
        add(0, 6'h23, 1, e_mread,    "lw c7 MEM_READ ready");
        add(0, 6'h23, 1, e_mwb,      "lw c8 MEM_WB");
        // SW with one wait cycle
        add(0, 6'h2B, 1, e_fetch_g,  "sw c1 FETCH");
        add(0, 6'h2B, 1, e_decode,   "sw c2 DECODE");
        add(0, 6'h2B, 1, e_maddr,    "sw c3 MEM_ADDR");
        add(0, 6'h2B, 0, e_mwrite_w, "sw c4 MEM_WRITE wait");
        add(0, 6'h2B, 1, e_mwrite_g, "sw c5 MEM_WRITE ready");
        // ADDI
        add(0, 6'h08, 1, e_fetch_g,  "addi c1 FETCH");
        add(0, 6'h08, 1, e_decode,   "addi c2 DECODE");
        add(0, 6'h08, 1, e_maddr,    "addi c3 ADDI_EXEC");
        add(0, 6'h08, 1, e_addi_wb,  "addi c4 ADDI_WB");
        // BEQ
        add(0, 6'h04, 1, e_fetch_g,  "beq c1 FETCH");
        add(0, 6'h04, 1, e_decode,   "beq c2 DECODE");
        add(0, 6'h04, 1, e_branch,   "beq c3 BRANCH");
        // J
        add(0, 6'h02, 1, e_fetch_g,  "j c1 FETCH");
        add(0, 6'h02, 1, e_decode,   "j c2 DECODE");
        add(0, 6'h02, 1, e_jump,     "j c3 JUMP");
        add(0, 6'h00, 0, e_fetch_w,  "after j FETCH");

        foreach (vecs[i]) step(vecs[i].r, vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].name);

        // Illegal opcode: FAULT after DECODE, sticky for 20 cycles, cleared by rst
        step(1, 6'h3F, 0, e_rst,     "illegal reset");
        step(0, 6'h3F, 1, e_fetch_g, "illegal FETCH");
        step(0, 6'h3F, 1, e_decode,  "illegal DECODE");
        for (int i = 0; i < 20; i++) step(0, 6'h00, 1'(i), e_fault, "illegal FAULT sticky");
        step(1, 6'h00, 1, e_rst,     "fault cleared by rst");
        step(0, 6'h00, 1, e_fetch_g, "post-fault FETCH");
        step(0, 6'h00, 1, e_decode,  "post-fault DECODE");

        // Timeout: 4 wait cycles in FETCH, still not ready on the next -> FAULT
        step(1, 6'h00, 0, e_rst,     "to reset");
        for (int i = 0; i < 4; i++) step(0, 6'h00, 0, e_fetch_w, "to FETCH wait");
        step(0, 6'h00, 0, e_fetch_w, "to FETCH at limit");
        step(0, 6'h00, 1, e_fault,   "to FAULT");

        // Ready arriving on the limit cycle completes normally
        step(1, 6'h00, 0, e_rst,     "lim reset");
        for (int i = 0; i < 4; i++) step(0, 6'h00, 0, e_fetch_w, "lim FETCH wait");
        step(0, 6'h00, 1, e_fetch_g, "lim FETCH ready at limit");
        step(0, 6'h00, 1, e_decode,  "lim DECODE no fault");
        step(0, 6'h00, 1, e_exec,    "lim EXECUTE");

        // rst mid-wait must clear the wait count
        step(1, 6'h00, 0, e_rst,     "clr reset");
        for (int i = 0; i < 3; i++) step(0, 6'h00, 0, e_fetch_w, "clr FETCH wait pre");
        step(1, 6'h00, 0, e_rst,     "clr reset mid-wait");
        for (int i = 0; i < 4; i++) step(0, 6'h00, 0, e_fetch_w, "clr FETCH wait post");
        step(0, 6'h00, 1, e_fetch_g, "clr FETCH ready");
        step(0, 6'h00, 1, e_decode,  "clr DECODE");

        // rst during MEM_WRITE wait: no instr_done, back to FETCH
        step(1, 6'h2B, 0, e_rst,      "swr reset");
        step(0, 6'h2B, 1, e_fetch_g,  "swr FETCH");
        step(0, 6'h2B, 1, e_decode,   "swr DECODE");
        step(0, 6'h2B, 1, e_maddr,    "swr MEM_ADDR");
        step(0, 6'h2B, 0, e_mwrite_w, "swr MEM_WRITE wait");
        step(0, 6'h2B, 0, e_mwrite_w, "swr MEM_WRITE wait");
        step(1, 6'h2B, 1, e_rst,      "swr rst during wait");
        step(0, 6'h2B, 0, e_fetch_w,  "swr FETCH after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum memory wait cycles before fault; 0 disables the timeout.
REQ-002 SHALL have parameter ALU_OP_W, default 2, the width of alu_op.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port opcode, input, 6, the instruction opcode from the external instruction register; valid from DECODE onward.
REQ-006 SHALL have port mem_ready, input, 1, memory handshake completion.
REQ-007 SHALL have output ports pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_2_reg, reg_dst, reg_write and alu_src_a, each 1 bit, as multicycle datapath controls.
REQ-008 SHALL have output ports alu_src_b (2), alu_op (ALU_OP_W) and pc_source (2): operand-B select, ALU class (0 add, 1 sub, 2 R-type) and PC source (0 ALU, 1 ALUOut, 2 jump target).
REQ-009 SHALL have output ports instr_done (1), a one-cycle retire pulse, and fault (1), a sticky error flag.

Function
REQ-010 SHALL implement the FSM states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP and FAULT.
REQ-011 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-012 FETCH SHALL drive mem_read=1, alu_src_b=1 and alu_op=0; it SHALL drive ir_write=pc_write=mem_ready (Mealy); it SHALL move to DECODE only when mem_ready=1, otherwise hold.
REQ-013 DECODE SHALL drive alu_src_b=3 and alu_op=0, then dispatch on opcode as follows.
  - 0x23 and 0x2B -> MEM_ADDR.
  - 0x00 -> EXECUTE.
  - 0x08 -> ADDI_EXEC.
  - 0x04 -> BRANCH.
  - 0x02 -> JUMP.
  - any other opcode -> FAULT.
REQ-014 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=0, then go to MEM_READ if the opcode is 0x23, else MEM_WRITE.
REQ-015 MEM_READ SHALL drive mem_read=1 and i_or_d=1, and hold until mem_ready, then go to MEM_WB.
REQ-016 MEM_WB SHALL drive reg_write=1, mem_2_reg=1 and reg_dst=0.
REQ-017 MEM_WRITE SHALL drive mem_write=1 and i_or_d=1, and hold until mem_ready.
REQ-018 EXECUTE SHALL drive alu_src_a=1, alu_src_b=0 and alu_op=2; R_WB SHALL drive reg_dst=1 and reg_write=1.
REQ-019 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=0; ADDI_WB SHALL drive reg_write=1 and reg_dst=0.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_op=1, pc_write_cond=1 and pc_source=1.
REQ-021 JUMP SHALL drive pc_write=1 and pc_source=2.
REQ-022 MEM_WB, MEM_WRITE (on mem_ready), R_WB, ADDI_WB, BRANCH and JUMP SHALL assert instr_done for one cycle and return to FETCH.
REQ-023 Instruction latency with zero wait states SHALL be:
  - LW 5 cycles;
  - SW, R-type and ADDI 4 cycles;
  - BEQ and J 3 cycles.
  Each wait cycle adds one.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEM_READ or MEM_WRITE and increment each cycle mem_ready=0 in those states.
REQ-025 When MEM_TIMEOUT>0 and the wait count equals MEM_TIMEOUT with mem_ready=0, the FSM SHALL go to FAULT.
REQ-026 mem_ready=1 in the same cycle as the count reaching MEM_TIMEOUT SHALL complete normally.
REQ-027 FAULT SHALL drive fault=1 with all other outputs 0, and SHALL be left only by rst.
REQ-028 The counter width SHALL be clog2(MEM_TIMEOUT+1), minimum 1, and the counter SHALL saturate and never wrap.

Reset
REQ-029 rst=1 at a clock edge SHALL force FETCH, clear the wait counter and clear fault, in any state including mid-wait.
REQ-030 While rst=1, all outputs SHALL be 0 except the FETCH Moore outputs (mem_read=1, alu_src_b=1, alu_op=0); ir_write and pc_write SHALL be 0 regardless of mem_ready.
REQ-031 The first FETCH after reset release SHALL behave as a normal fetch.

Structure
REQ-032 Opcode constants, alu_op codes, pc_source codes and the state enumeration SHALL live in shared package mips_ctrl_pkg, reused by the existing single-cycle decoder.
REQ-033 The wait counter SHALL be a sub-module mem_wait_timer (parameter MEM_TIMEOUT; inputs clk, rst, clear, count_en; output expired).

Verification
REQ-034 SHALL cover: reset, opcode 0x00, mem_ready=1 always -> states FETCH, DECODE, EXECUTE, R_WB; instr_done at cycle 4; alu_op=2 in EXECUTE.
REQ-035 SHALL cover: opcode 0x23, mem_ready low 3 cycles in MEM_READ -> instr_done at cycle 8; reg_write=mem_2_reg=1 in MEM_WB only.
REQ-036 SHALL cover: opcode 0x04 -> pc_write_cond=1, pc_source=1, alu_op=1 in cycle 3, then FETCH.
REQ-037 SHALL cover: opcode 0x3F -> FAULT after DECODE; fault stays 1 for 20 cycles; rst -> fault=0, state FETCH.
REQ-038 SHALL cover: MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after the 4th wait cycle; mem_ready=1 exactly on the 4th wait cycle instead -> DECODE, no fault.
REQ-039 SHALL cover: rst asserted during a MEM_WRITE wait -> next cycle FETCH with mem_write=0 and no instr_done.
